// File: rtl/btn_evt_pkg.sv
// Shared types and default thresholds for the push-button event generator.
// Holds the FSM state encoding and a helper that checks counter width against thresholds.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    localparam int DEF_DEB_CYCLES    = 50000;
    localparam int DEF_LONG_CYCLES   = 50000000;
    localparam int DEF_REPEAT_CYCLES = 10000000;
    localparam int DEF_CNT_W         = 26;

    localparam int SYNC_STAGES = 2;

    // True when every threshold is at least 2 and its terminal count fits in cnt_w bits.
    function automatic bit cnt_fits(input int cnt_w, input int deb, input int lng, input int rep);
        longint lim;
        lim = longint'(1) << cnt_w;
        return (deb >= 2) && (lng >= 2) && (rep >= 2) &&
               (longint'(deb - 1) < lim) &&
               (longint'(lng - 1) < lim) &&
               (longint'(rep - 1) < lim);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-stage synchroniser followed by a stability-count debouncer.
// btn_clean follows the synchronised pin only after DEB_CYCLES consecutive differing samples.
module btn_debounce
    import btn_evt_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_next;
    logic                   w_btn_s;
    logic [CNT_W-1:0]       r_deb_cnt;
    logic                   r_clean;

    assign w_sync_next = {r_sync[SYNC_STAGES-2:0], btn_raw};
    assign w_btn_s     = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_sync_next;
        end
    end

    // Any sample agreeing with the current level restarts the stability window.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_deb_cnt <= '0;
            r_clean   <= 1'b0;
        end else if (w_btn_s == r_clean) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_LAST) begin
            r_clean   <= w_btn_s;
            r_deb_cnt <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

    assign btn_clean = r_clean;

endmodule

// File: rtl/btn_event_gen.sv
// Push-button front-end: debounced level plus single-cycle press/short/long events.
// Optional auto-repeat while held past the long threshold is enabled by BTN_EVT_REPEAT_EN.
module btn_event_gen
    import btn_evt_pkg::*;
#(
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean,
    output logic evt_press,
    output logic evt_short,
    output logic evt_long,
    output logic evt_rep
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    if (!cnt_fits(CNT_W, DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) begin : g_cfg_bad
        $error("btn_event_gen: thresholds must be >= 2 and fit in CNT_W bits");
    end

    logic w_clean;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_clean (w_clean)
    );

    btn_state_t       r_state;
    btn_state_t       w_state_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;
    logic             r_evt_press;
    logic             r_evt_short;
    logic             r_evt_long;
    logic             w_evt_press_next;
    logic             w_evt_short_next;
    logic             w_evt_long_next;

`ifdef BTN_EVT_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [CNT_W-1:0] r_rep_cnt;
    logic [CNT_W-1:0] w_rep_cnt_next;
    logic             r_evt_rep;
    logic             w_evt_rep_next;
`endif

    // State, counters and event outputs are all registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            r_evt_press <= 1'b0;
            r_evt_short <= 1'b0;
            r_evt_long  <= 1'b0;
`ifdef BTN_EVT_REPEAT_EN
            r_rep_cnt   <= '0;
            r_evt_rep   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_next;
            r_hold_cnt  <= w_hold_cnt_next;
            r_evt_press <= w_evt_press_next;
            r_evt_short <= w_evt_short_next;
            r_evt_long  <= w_evt_long_next;
`ifdef BTN_EVT_REPEAT_EN
            r_rep_cnt   <= w_rep_cnt_next;
            r_evt_rep   <= w_evt_rep_next;
`endif
        end
    end

    // A release always takes priority over reaching the long threshold.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_clean) begin
                    w_state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!w_clean) begin
                    w_state_next = IDLE;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_state_next = LONG;
                end
            end
            LONG: begin
                if (!w_clean) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_evt_press_next = 1'b0;
        w_evt_short_next = 1'b0;
        w_evt_long_next  = 1'b0;
        w_hold_cnt_next  = r_hold_cnt;
`ifdef BTN_EVT_REPEAT_EN
        w_evt_rep_next   = 1'b0;
        w_rep_cnt_next   = r_rep_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (w_clean) begin
                    w_evt_press_next = 1'b1;
                    w_hold_cnt_next  = '0;
                end
            end
            PRESSED: begin
                if (!w_clean) begin
                    w_evt_short_next = 1'b1;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_evt_long_next  = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
                    w_rep_cnt_next   = '0;
`endif
                end else begin
                    w_hold_cnt_next  = r_hold_cnt + 1'b1;
                end
            end
            LONG: begin
`ifdef BTN_EVT_REPEAT_EN
                if (w_clean) begin
                    if (r_rep_cnt == REP_LAST) begin
                        w_evt_rep_next = 1'b1;
                        w_rep_cnt_next = '0;
                    end else begin
                        w_rep_cnt_next = r_rep_cnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                w_hold_cnt_next = '0;
            end
        endcase
    end

    assign btn_clean = w_clean;
    assign evt_press = r_evt_press;
    assign evt_short = r_evt_short;
    assign evt_long  = r_evt_long;
`ifdef BTN_EVT_REPEAT_EN
    assign evt_rep   = r_evt_rep;
`else
    assign evt_rep   = 1'b0;
`endif

endmodule
